// File: rtl/discriminante_seq_if.sv
// ----------------------------------------------------------------------------
// discriminante_seq_if
//
// Purpose: start/done handshake plus operand and result bus of the sequential
// discriminant unit. The requester (master) drives the request and the three
// coefficients; the unit (slave) returns status and the registered result.
//
// Signals:
//   start  master->slave  request, only honoured while the unit is idle
//   a,b,c  master->slave  unsigned N-bit coefficients
//   busy   slave->master  computation in progress
//   done   slave->master  one-cycle pulse, result newly valid
//   s      slave->master  |b*b - 4*a*c|, OW = 2*N+2 bits
//   neg    slave->master  4*a*c > b*b
//   zero   slave->master  b*b == 4*a*c
// ----------------------------------------------------------------------------
interface discriminante_seq_if #(
    parameter int N = 4
);
    localparam int OW = 2 * N + 2;

    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [N-1:0]  c;
    logic          busy;
    logic          done;
    logic [OW-1:0] s;
    logic          neg;
    logic          zero;

    modport master (
        output start, a, b, c,
        input  busy, done, s, neg, zero
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, s, neg, zero
    );
endinterface

// File: rtl/discriminante_seq.sv
// ----------------------------------------------------------------------------
// discriminante_seq
//
// Purpose: computes the magnitude and sign of D = b*b - 4*a*c for unsigned
// N-bit operands with a single shared shift-add multiplier. The first pass
// squares b, the second pass forms a*c, the factor of four is pure wiring,
// and a final cycle compares and subtracts. Latency is 2N+2 cycles from the
// accepted start to the done pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, abandons any computation in flight
//   bus   slave side of discriminante_seq_if (start, a, b, c in;
//         busy, done, s, neg, zero out)
// ----------------------------------------------------------------------------
module discriminante_seq #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    discriminante_seq_if.slave  bus
);
    localparam int OW = 2 * N + 2;
    localparam int PW = 2 * N;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MBB  = 3'd1,
        MAC  = 3'd2,
        SUB  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nx;

    // Latched a and c feed the second multiplier pass. b needs no separate
    // holding register: it is loaded straight into the multiplier at start.
    logic [N-1:0]   ra;
    logic [N-1:0]   rc;

    // Shift-add multiplier: the multiplicand shifts left and the multiplier
    // shifts right, so bit 0 of mplier is always the bit being processed.
    logic [PW-1:0]  mcand;
    logic [N-1:0]   mplier;
    logic [PW-1:0]  acc;
    logic [CW-1:0]  cnt;

    logic [PW-1:0]  p1;
    logic [OW-1:0]  p2;

    logic [OW-1:0]  s_q;
    logic           neg_q;
    logic           zero_q;

    logic [PW-1:0]  addend;
    logic [PW-1:0]  acc_sum;
    logic           last_bit;
    logic [OW-1:0]  p1x;
    logic           p2_gt;
    logic [OW-1:0]  diff;

    // One partial product per cycle; the product of two N-bit values always
    // fits in 2N bits, so the accumulator never overflows.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        acc_sum  = acc + addend;
        last_bit = (cnt == LAST);
    end

    // Unsigned compare/subtract of b*b (zero-extended) against 4*a*c.
    always_comb begin
        p1x   = {2'b00, p1};
        p2_gt = (p2 > p1x);
        diff  = p2_gt ? (p2 - p1x) : (p1x - p2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = MBB;
            MBB:     if (last_bit)  state_nx = MAC;
            MAC:     if (last_bit)  state_nx = SUB;
            SUB:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rc     <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p1     <= '0;
            p2     <= '0;
            s_q    <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra     <= bus.a;
                        rc     <= bus.c;
                        mcand  <= {{N{1'b0}}, bus.b};
                        mplier <= bus.b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MBB: begin
                    if (last_bit) begin
                        // b*b complete; reload the multiplier with a and c.
                        p1     <= acc_sum;
                        mcand  <= {{N{1'b0}}, ra};
                        mplier <= rc;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                MAC: begin
                    if (last_bit) begin
                        // Times four is just two zero bits appended.
                        p2     <= {acc_sum, 2'b00};
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                SUB: begin
                    s_q    <= diff;
                    neg_q  <= p2_gt;
                    zero_q <= (p2 == p1x);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state == MBB) || (state == MAC) || (state == SUB);
    assign bus.done = (state == DONE);
    assign bus.s    = s_q;
    assign bus.neg  = neg_q;
    assign bus.zero = zero_q;
endmodule
